axil_mem_slave: RTL and testbench
=================================

Name: axil_mem_slave

Overview:
Parametrised AXI4-Lite memory slave, the next generation of the team's single-word AXI-Lite memory. It adds configurable data width and depth, byte-lane write strobes, independent acceptance of the AW and W channels, and SLVERR for out-of-range accesses. The write and read paths run concurrently. The block sits behind the interconnect as a scratch/register memory, and the same AXI-Lite master bench drives it.

Parameters:
DATA_W, 32, data bus width in bits; legal values are 32 and 64.
ADDR_W, 32, byte address width.
DEPTH, 64, number of DATA_W-bit words; must be a power of two, at least 2.

Ports:
s_axi_aclk  in  1  clock; all logic is rising-edge.
s_axi_areset  in  1  synchronous, active-high reset.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address ready.
s_axi_awaddr  in  ADDR_W  write byte address.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data ready.
s_axi_wdata  in  DATA_W  write data.
s_axi_wstrb  in  DATA_W/8  byte-lane enables.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
s_axi_arvalid  in  1  read address valid.
s_axi_arready  out  1  read address ready.
s_axi_araddr  in  ADDR_W  read byte address.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data ready.
s_axi_rdata  out  DATA_W  read data.
s_axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR.

Behaviour:
- Reset: while s_axi_areset is high at a rising edge, every output is forced to 0 (including all readies), all holding registers are cleared, and no memory write occurs. Memory contents are not cleared. The readies may assert in the first cycle after reset deasserts.
- Addressing: word index = addr >> log2(DATA_W/8). Low offset bits are ignored, so unaligned addresses are truncated. An index >= DEPTH is out of range.
- Write path holds two registers, aw_held and w_held, plus bvalid.
- awready = !aw_held && !bvalid. wready = !w_held && !bvalid. Both are combinational from registered state.
- An AW handshake captures awaddr and sets aw_held. A W handshake captures wdata/wstrb and sets w_held. AW and W may arrive in either order or in the same cycle.
- When aw_held && w_held, on the next edge:
  - commit the write to memory, updating only the byte lanes whose wstrb bit is 1 (an in-range write with wstrb=0 is a legal no-op, OKAY);
  - clear both held flags;
  - set bvalid with bresp = 10 if the address is out of range (memory untouched), otherwise 00.
- Latency: with AW and W both accepted at edge N, the memory is written at edge N+1 and bvalid is high after N+1.
- bvalid and bresp hold until bvalid && bready; bvalid clears on that edge. No new AW or W is accepted while bvalid is high, so there is at most one write outstanding.
- Read path: arready = !rvalid.
- An AR handshake at edge N registers rdata at edge N, and rvalid is high after N (1-cycle latency).
  - Out-of-range reads return rdata = 0 and rresp = 10.
  - rdata and rresp are stable until rvalid && rready, at which rvalid clears.
- Read/write same word in the same cycle: the array is dual-ported. A read sampled at the same edge as a write commit returns the old data; there is no bypass.
- Valid inputs dropping before a handshake are ignored; no state is captured without a handshake.
- Synthesis target: inferred RAM with per-byte write enables.

Test Plan:
1. DATA_W=32, DEPTH=64: AW 0x14 and W 0xC0DECAFE, wstrb=F, in the same cycle; bready=1 → bvalid one cycle after the handshake, bresp=00. Then AR 0x14 with rready=1 → rdata=0xC0DECAFE, rresp=00, rvalid one cycle after the AR handshake.
2. W 0x11223344 to address 0x08 presented 3 cycles before AW → wready low after W acceptance, no bvalid until AW is accepted, bvalid one cycle after AW. Readback of 0x08 = 0x11223344.
3. Strobes: after test 1, write 0x12345678 to 0x14 with wstrb=4'b0011 → bresp=00, readback 0xC0DE5678. A wstrb=0 write leaves 0xC0DE5678 unchanged.
4. Out of range: write to 0x100 (index 64) → bresp=10, and a read of word 0 is unchanged. AR 0x100 → rdata=0, rresp=10.
5. Backpressure: bready held low 5 cycles → bvalid/bresp stable, awready=wready=0, and a pending AW is not accepted until the cycle after the B handshake. rready held low 4 cycles → rdata stable, arready=0.
6. Reset mid-op: assert reset with aw_held set and rvalid high → all outputs 0 next cycle, the pending write is never committed, and the previously stored word reads back unchanged after reset.

Source files
------------

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory slave: parametrised width/depth, byte-lane strobes,
// independent AW/W capture, SLVERR on out-of-range word indices.
// Write and read paths are fully independent and run concurrently.
module axil_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_areset,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic [1:0]          s_axi_bresp,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write-path state
    logic              aw_held_q, aw_held_d;
    logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic              w_held_q,  w_held_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0] wstrb_q,   wstrb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;

    // Read-path state
    logic              rvalid_q,  rvalid_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    // Keeps all readies low during the cycle that follows a reset edge
    logic              in_reset_q;

    logic              aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [ADDR_W-1:0] aw_word_s, ar_word_s;
    logic              aw_in_range_s, ar_in_range_s;
    logic [IDX_W-1:0]  aw_idx_s, ar_idx_s;

    // Word index decode; anything at or beyond DEPTH is out of range
    assign aw_word_s     = awaddr_q >> OFF_W;
    assign ar_word_s     = s_axi_araddr >> OFF_W;
    assign aw_in_range_s = (aw_word_s < ADDR_W'(DEPTH));
    assign ar_in_range_s = (ar_word_s < ADDR_W'(DEPTH));
    assign aw_idx_s      = aw_word_s[IDX_W-1:0];
    assign ar_idx_s      = ar_word_s[IDX_W-1:0];

    // Readies depend only on registered state
    assign s_axi_awready = !in_reset_q && !aw_held_q && !bvalid_q;
    assign s_axi_wready  = !in_reset_q && !w_held_q  && !bvalid_q;
    assign s_axi_arready = !in_reset_q && !rvalid_q;

    assign aw_hs_s  = s_axi_awvalid && s_axi_awready;
    assign w_hs_s   = s_axi_wvalid  && s_axi_wready;
    assign ar_hs_s  = s_axi_arvalid && s_axi_arready;
    assign commit_s = aw_held_q && w_held_q;

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;

    // Write path next state: capture AW/W independently, commit once both are held
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_range_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs_s) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_axi_awaddr;
            end else begin
                aw_held_d = aw_held_q;
            end
            if (w_hs_s) begin
                w_held_d = 1'b1;
                wdata_d  = s_axi_wdata;
                wstrb_d  = s_axi_wstrb;
            end else begin
                w_held_d = w_held_q;
            end
            if (bvalid_q && s_axi_bready) begin
                bvalid_d = 1'b0;
            end else begin
                bvalid_d = bvalid_q;
            end
        end
    end

    // Read path next state: one-cycle registered read, held until accepted
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            if (ar_in_range_s) begin
                rdata_d = mem_q[ar_idx_s];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // Control/holding registers with synchronous reset
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            in_reset_q <= 1'b1;
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            in_reset_q <= 1'b0;
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Storage array: byte-lane write on commit; contents survive reset
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_areset && commit_s && aw_in_range_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) begin
                    mem_q[aw_idx_s][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_slave.sv
// Self-checking bench for axil_mem_slave (DATA_W=32, DEPTH=64): directed
// scenarios plus randomized traffic against an array-based reference memory.
module tb_axil_mem_slave;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;

    logic        clk = 1'b0;
    logic        areset;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    axil_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .s_axi_aclk(clk), .s_axi_areset(areset),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp)
    );

    // ---------------- reference model ----------------
    function automatic bit ref_in_range(input logic [31:0] a);
        return (a / 32'd4) < 32'(DEPTH);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
        logic [31:0] res;
        logic [31:0] mask;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            mask = 32'hFF << (8 * b);
            if (strb[b]) res = (res & ~mask) | (new_w & mask);
        end
        return res;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (ref_in_range(a)) ref_mem[a / 32'd4] = ref_merge(ref_mem[a / 32'd4], d, s);
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_in_range(a) ? ref_mem[a / 32'd4] : 32'h0;
    endfunction

    function automatic logic [1:0] ref_resp(input logic [31:0] a);
        return ref_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat = edges after the last AW/W handshake edge until bvalid is seen
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int lat, output bit cleared, output bit ok);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        cyc = 0; aw_done = 1'b0; w_done = 1'b0; ok = 1'b1; cleared = 1'b0;
        bready = 1'b1;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) ok = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            tick();
            lat++;
        end
        resp = bresp;
        tick();
        cleared = !bvalid;
    endtask

    // lat = edges after the AR handshake edge until rvalid is seen
    task automatic read_txn(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output bit cleared, output bit ok);
        int n;
        n = 0; ok = 1'b1;
        rready = 1'b1; arvalid = 1'b1; araddr = addr;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) ok = 1'b0;
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        data = rdata; resp = rresp;
        tick();
        cleared = !rvalid;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [40:0] outs;
        areset = 1'b1;
        tick(); tick();
        outs = {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp};
        checks++;
        if (outs !== 41'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        areset = 1'b0;
        tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_release: got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
        end
    endtask

    task automatic test_fill();
        logic [31:0] d; logic [1:0] resp; int lat; bit clr, ok;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            write_txn(32'(i) * 32'd4, d, 4'hF, 0, 0, resp, lat, clr, ok);
            model_write(32'(i) * 32'd4, d, 4'hF);
            checks++;
            if (resp !== 2'b00 || lat != 1 || !clr || !ok) begin
                errors++;
                $display("FAIL fill_write[%0d]: got resp=%b lat=%0d clr=%0b ok=%0b expected resp=00 lat=1 clr=1 ok=1",
                         i, resp, lat, clr, ok);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [1:0] resp; int lat; bit clr, ok;
        write_txn(32'h14, 32'hC0DECAFE, 4'hF, 0, 0, resp, lat, clr, ok);
        model_write(32'h14, 32'hC0DECAFE, 4'hF);
        checks++;
        if (resp !== 2'b00 || !ok || !clr) begin errors++; $display("FAIL basic_bresp: got %b expected 00", resp); end
        checks++;
        if (lat != 1) begin errors++; $display("FAIL basic_b_latency: got %0d expected 1", lat); end
        read_txn(32'h14, d, resp, lat, clr, ok);
        checks++;
        if (d !== 32'hC0DECAFE) begin errors++; $display("FAIL basic_rdata: got %h expected c0decafe", d); end
        checks++;
        if (resp !== 2'b00 || lat != 0 || !clr || !ok) begin
            errors++;
            $display("FAIL basic_read_resp_lat: got resp=%b lat=%0d expected resp=00 lat=0", resp, lat);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d; logic [1:0] resp; int lat; bit clr, ok;
        bready = 1'b1;
        wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF;
        tick();                       // W accepted here (wready was high)
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wready !== 1'b0 || bvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_first_hold[%0d]: got wready=%b bvalid=%b expected 0 0", c, wready, bvalid);
            end
            if (c < 2) tick();
        end
        awvalid = 1'b1; awaddr = 32'h08;
        tick();                       // AW accepted
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("FAIL w_first_early_b: got %b expected 0", bvalid); end
        tick();
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL w_first_b: got bvalid=%b bresp=%b expected 1 00", bvalid, bresp);
        end
        tick();
        model_write(32'h08, 32'h11223344, 4'hF);
        read_txn(32'h08, d, resp, lat, clr, ok);
        checks++;
        if (d !== 32'h11223344 || resp !== 2'b00) begin
            errors++;
            $display("FAIL w_first_readback: got %h/%b expected 11223344/00", d, resp);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] d; logic [1:0] resp; int lat; bit clr, ok;
        write_txn(32'h14, 32'h12345678, 4'b0011, 0, 0, resp, lat, clr, ok);
        model_write(32'h14, 32'h12345678, 4'b0011);
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL strb_bresp: got %b expected 00", resp); end
        read_txn(32'h14, d, resp, lat, clr, ok);
        checks++;
        if (d !== 32'hC0DE5678) begin errors++; $display("FAIL strb_partial: got %h expected c0de5678", d); end
        write_txn(32'h14, 32'hFFFFFFFF, 4'b0000, 1, 0, resp, lat, clr, ok);
        checks++;
        if (resp !== 2'b00 || lat != 1) begin
            errors++;
            $display("FAIL strb_zero_resp: got resp=%b lat=%0d expected 00 1", resp, lat);
        end
        read_txn(32'h14, d, resp, lat, clr, ok);
        checks++;
        if (d !== 32'hC0DE5678) begin errors++; $display("FAIL strb_zero_noop: got %h expected c0de5678", d); end
        // Unaligned address is truncated to word 5
        write_txn(32'h17, 32'hAA000000, 4'b1000, 0, 2, resp, lat, clr, ok);
        model_write(32'h17, 32'hAA000000, 4'b1000);
        read_txn(32'h15, d, resp, lat, clr, ok);
        checks++;
        if (d !== 32'hAADE5678 || d !== ref_read(32'h14)) begin
            errors++;
            $display("FAIL strb_unaligned: got %h expected aade5678", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d, w0; logic [1:0] resp; int lat; bit clr, ok;
        w0 = ref_mem[0];
        write_txn(32'h100, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat, clr, ok);
        checks++;
        if (resp !== 2'b10 || lat != 1 || !clr) begin
            errors++;
            $display("FAIL oor_bresp: got resp=%b lat=%0d expected 10 1", resp, lat);
        end
        read_txn(32'h0, d, resp, lat, clr, ok);
        checks++;
        if (d !== w0 || resp !== 2'b00) begin errors++; $display("FAIL oor_word0_intact: got %h expected %h", d, w0); end
        read_txn(32'h100, d, resp, lat, clr, ok);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10 || lat != 0) begin
            errors++;
            $display("FAIL oor_read: got %h/%b expected 0/10", d, resp);
        end
        read_txn(32'hFFFFFFF0, d, resp, lat, clr, ok);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10) begin errors++; $display("FAIL oor_read_high: got %h/%b expected 0/10", d, resp); end
        write_txn(32'hFC, 32'h5A5AA5A5, 4'hF, 0, 0, resp, lat, clr, ok);
        model_write(32'hFC, 32'h5A5AA5A5, 4'hF);
        read_txn(32'hFC, d, resp, lat, clr, ok);
        checks++;
        if (d !== 32'h5A5AA5A5 || resp !== 2'b00) begin
            errors++;
            $display("FAIL last_word: got %h/%b expected 5a5aa5a5/00", d, resp);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d1, d2, dd; logic [1:0] resp; int lat; bit clr, ok;
        d1 = $urandom; d2 = $urandom;
        bready = 1'b0;
        awvalid = 1'b1; awaddr = 32'h20; wvalid = 1'b1; wdata = d1; wstrb = 4'hF;
        tick();                       // first AW+W accepted
        wvalid = 1'b0;
        awaddr = 32'h24;              // second AW waits behind the response
        tick();                       // commit, bvalid rises
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_stall[%0d]: got bvalid=%b bresp=%b awready=%b wready=%b expected 1 00 0 0",
                         c, bvalid, bresp, awready, wready);
            end
            tick();
        end
        bready = 1'b1;
        tick();                       // B handshake
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL b_release: got bvalid=%b awready=%b expected 0 1", bvalid, awready);
        end
        tick();                       // second AW accepted
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = d2;
        tick();                       // W accepted
        wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat != 1 || bresp !== 2'b00) begin errors++; $display("FAIL b_second: got lat=%0d bresp=%b expected 1 00", lat, bresp); end
        tick();
        model_write(32'h20, d1, 4'hF);
        model_write(32'h24, d2, 4'hF);
        // Read backpressure with a second AR waiting
        rready = 1'b0; arvalid = 1'b1; araddr = 32'h20;
        tick();                       // AR accepted
        araddr = 32'h24;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== ref_mem[8] || rresp !== 2'b00 || arready !== 1'b0) begin
                errors++;
                $display("FAIL r_stall[%0d]: got rvalid=%b rdata=%h arready=%b expected 1 %h 0",
                         c, rvalid, rdata, arready, ref_mem[8]);
            end
            tick();
        end
        rready = 1'b1;
        tick();                       // R handshake
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL r_release: got rvalid=%b arready=%b expected 0 1", rvalid, arready);
        end
        tick();                       // second AR accepted
        arvalid = 1'b0;
        dd = rdata;
        checks++;
        if (rvalid !== 1'b1 || dd !== ref_mem[9]) begin
            errors++;
            $display("FAIL r_second: got rvalid=%b rdata=%h expected 1 %h", rvalid, dd, ref_mem[9]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [40:0] outs; logic [31:0] d, old; logic [1:0] resp; int lat; bit clr, ok;
        old = ref_mem[12];
        rready = 1'b0; arvalid = 1'b1; araddr = 32'h30;
        tick();
        arvalid = 1'b0;
        awvalid = 1'b1; awaddr = 32'h30;
        tick();                       // AW held, rvalid pending
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = ~old; wstrb = 4'hF;
        areset = 1'b1;
        tick();
        outs = {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp};
        checks++;
        if (outs !== 41'h0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
        wvalid = 1'b0;
        areset = 1'b0;
        tick(); tick();
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_no_commit: got bvalid=%b awready=%b wready=%b expected 0 1 1", bvalid, awready, wready);
        end
        read_txn(32'h30, d, resp, lat, clr, ok);
        checks++;
        if (d !== old || resp !== 2'b00) begin errors++; $display("FAIL midreset_word: got %h expected %h", d, old); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, got; logic [3:0] s; logic [1:0] resp; int lat; bit clr, ok;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'h100 + 32'($urandom_range(0, 65535));
            else a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                write_txn(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat, clr, ok);
                checks++;
                if (resp !== ref_resp(a) || lat != 1 || !clr || !ok) begin
                    errors++;
                    $display("FAIL rand_write[%0d] addr=%h: got resp=%b lat=%0d expected resp=%b lat=1",
                             i, a, resp, lat, ref_resp(a));
                end
                model_write(a, d, s);
            end else begin
                read_txn(a, got, resp, lat, clr, ok);
                checks++;
                if (got !== ref_read(a) || resp !== ref_resp(a) || lat != 0 || !clr || !ok) begin
                    errors++;
                    $display("FAIL rand_read[%0d] addr=%h: got %h/%b lat=%0d expected %h/%b lat=0",
                             i, a, got, resp, lat, ref_read(a), ref_resp(a));
                end
            end
        end
    endtask

    initial begin
        areset = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
        #1;
        test_reset();
        test_fill();
        test_basic();
        test_w_before_aw();
        test_strobes();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
